pipelined_adder_n: RTL and testbench

- Parametrised N-bit adder/subtractor split into STAGES registered carry-chain segments, each segment W = N/STAGES bits wide.
- Throughput is one operation per clock. A valid/ready handshake and a global stall let it sit on datapath streams between producer and consumer blocks.
- Generalises the plain ripple-carry adder with: pipelining, an add/subtract mode, per-operation carry-in, and status flags (carry, signed overflow, zero).

---
 rtl/pipelined_adder_n.sv | 131 +++++++++++++
 tb/tb_pipelined_adder_n.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_n.sv
// N-bit adder/subtractor split into STAGES registered carry-chain segments.
// Valid/ready streaming with a global stall; flags are produced alongside the last segment.
module pipelined_adder_n #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);
    localparam int W = N / STAGES;

    if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder_n: STAGES must divide N and lie in 1..N");
    end

    logic         en;
    logic [N-1:0] pipe_a   [STAGES];
    logic [N-1:0] pipe_bb  [STAGES];
    logic [N-1:0] pipe_sum [STAGES+1];
    logic         pipe_c   [STAGES+1];
    logic         pipe_v   [STAGES+1];
    logic [N-1:0] last_sum_d;

    // One enable for the whole pipe: it advances whenever the output slot frees up.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    assign pipe_a[0]   = a;
    assign pipe_bb[0]  = sub ? ~b : b;
    assign pipe_c[0]   = sub ? ~cin : cin;
    assign pipe_sum[0] = '0;
    assign pipe_v[0]   = in_valid;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO = gi * W;

        logic [W:0]   chunk_add;
        logic [N-1:0] sum_d, sum_q;
        logic         carry_d, carry_q;
        logic         valid_d, valid_q;

        always_comb begin
            chunk_add = {1'b0, pipe_a[gi][LO +: W]} + {1'b0, pipe_bb[gi][LO +: W]}
                      + {{W{1'b0}}, pipe_c[gi]};
            sum_d            = pipe_sum[gi];
            sum_d[LO +: W]   = chunk_add[W-1:0];
            carry_d          = chunk_add[W];
            valid_d          = pipe_v[gi];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
                valid_q <= 1'b0;
            end else if (en) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
                valid_q <= valid_d;
            end
        end

        assign pipe_sum[gi+1] = sum_q;
        assign pipe_c[gi+1]   = carry_q;
        assign pipe_v[gi+1]   = valid_q;

        // Operands still to be added (and the MSBs needed for overflow) ride along in skew registers.
        if (gi < STAGES - 1) begin : g_fwd
            logic [N-1:0] a_d, a_q, bb_d, bb_q;

            always_comb begin
                a_d  = pipe_a[gi];
                bb_d = pipe_bb[gi];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q  <= '0;
                    bb_q <= '0;
                end else if (en) begin
                    a_q  <= a_d;
                    bb_q <= bb_d;
                end
            end

            assign pipe_a[gi+1]  = a_q;
            assign pipe_bb[gi+1] = bb_q;
        end

        if (gi == STAGES - 1) begin : g_last
            assign last_sum_d = sum_d;
        end
    end

    logic ovf_d, ovf_q, zero_d, zero_q;

    always_comb begin
        ovf_d  = (pipe_a[STAGES-1][N-1] == pipe_bb[STAGES-1][N-1])
               & (last_sum_d[N-1] != pipe_a[STAGES-1][N-1]);
        zero_d = (last_sum_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (en) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = pipe_v[STAGES];
    assign sum       = pipe_sum[STAGES];
    assign cout      = pipe_c[STAGES];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder_n.sv
// Self-checking bench: three configurations (8/2, 16/4, 8/1) against an arithmetic reference model.
module tb_pipelined_adder_n;
    typedef struct packed {
        logic        ovf;
        logic        zero;
        logic        cout;
        logic [15:0] sum;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, cin, sub, out_ready;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;

    logic        in_ready0, out_valid0, cout0, ovf0, zero0;
    logic [7:0]  sum0;
    logic        in_ready1, out_valid1, cout1, ovf1, zero1;
    logic [15:0] sum1;
    logic        in_ready2, out_valid2, cout2, ovf2, zero2;
    logic [7:0]  sum2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipelined_adder_n #(.N(8), .STAGES(2)) dut_n8s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a8), .b(b8), .cin(cin), .sub(sub),
        .out_valid(out_valid0), .out_ready(out_ready),
        .sum(sum0), .cout(cout0), .ovf(ovf0), .zero(zero0)
    );

    pipelined_adder_n #(.N(16), .STAGES(4)) dut_n16s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a16), .b(b16), .cin(cin), .sub(sub),
        .out_valid(out_valid1), .out_ready(out_ready),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1)
    );

    pipelined_adder_n #(.N(8), .STAGES(1)) dut_n8s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a8), .b(b8), .cin(cin), .sub(sub),
        .out_valid(out_valid2), .out_ready(out_ready),
        .sum(sum2), .cout(cout2), .ovf(ovf2), .zero(zero2)
    );

    // Reference: plain integer arithmetic on n-bit unsigned/signed interpretations.
    function automatic res_t ref_op(input int n, input logic [15:0] av, input logic [15:0] bv,
                                    input logic ci, input logic su);
        longint m, half, ua, ub, sa, sb, c, ures, ideal, s;
        res_t   r;
        m    = longint'(1) << n;
        half = m / 2;
        ua   = longint'(av) % m;
        ub   = longint'(bv) % m;
        c    = longint'(ci);
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        if (su) begin
            ures   = ua - ub - c;
            ideal  = sa - sb - c;
            r.cout = (ures >= 0);
        end else begin
            ures   = ua + ub + c;
            ideal  = sa + sb + c;
            r.cout = (ures >= m);
        end
        s      = ((ures % m) + m) % m;
        r.sum  = 16'(s);
        r.zero = (s == 0);
        r.ovf  = (ideal < -half) || (ideal >= half);
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] s, input logic c,
                                input logic v, input logic z, input res_t e);
        check_eq({tag, " sum"},  {16'h0, s}, {16'h0, e.sum});
        check_eq({tag, " cout"}, {31'h0, c}, {31'h0, e.cout});
        check_eq({tag, " ovf"},  {31'h0, v}, {31'h0, e.ovf});
        check_eq({tag, " zero"}, {31'h0, z}, {31'h0, e.zero});
    endtask

    // One op into all three pipes; measure latency in clock edges and check the result.
    task automatic run_directed(input string tag, input logic [7:0] av8, input logic [7:0] bv8,
                                input logic [15:0] av16, input logic [15:0] bv16,
                                input logic ci, input logic su);
        res_t e0, e1, e2;
        int   lat0, lat1, lat2;
        e0 = ref_op(8, {8'h0, av8}, {8'h0, bv8}, ci, su);
        e1 = ref_op(16, av16, bv16, ci, su);
        e2 = ref_op(8, {8'h0, av8}, {8'h0, bv8}, ci, su);
        lat0 = -1; lat1 = -1; lat2 = -1;
        @(negedge clk);
        a8 = av8; b8 = bv8; a16 = av16; b16 = bv16; cin = ci; sub = su;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid0 && lat0 < 0) begin
                lat0 = e;
                check_result({tag, " n8s2"}, {8'h0, sum0}, cout0, ovf0, zero0, e0);
            end
            if (out_valid1 && lat1 < 0) begin
                lat1 = e;
                check_result({tag, " n16s4"}, sum1, cout1, ovf1, zero1, e1);
            end
            if (out_valid2 && lat2 < 0) begin
                lat2 = e;
                check_result({tag, " n8s1"}, {8'h0, sum2}, cout2, ovf2, zero2, e2);
            end
        end
        check_eq({tag, " latency n8s2"}, lat0, 2);
        check_eq({tag, " latency n16s4"}, lat1, 4);
        check_eq({tag, " latency n8s1"}, lat2, 1);
        $display("op %s: n8s2 sum=%h lat=%0d | n16s4 sum=%h lat=%0d | n8s1 sum=%h lat=%0d",
                 tag, sum0, lat0, sum1, lat1, sum2, lat2);
    endtask

    // 20 random ops through the 8/2 pipe with a randomly stalling consumer.
    task automatic run_stream();
        res_t q[$];
        int   accepted, delivered, cyc;
        logic fire;
        accepted = 0; delivered = 0; cyc = 0;
        @(negedge clk);
        a8 = 8'($urandom); b8 = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        while ((accepted < 20 || q.size() > 0) && cyc < 400) begin
            in_valid  = (accepted < 20);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            check_eq("stream in_ready", {31'h0, in_ready0}, {31'h0, ~out_valid0 | out_ready});
            if (out_valid0) begin
                check_eq("stream result pending", {31'h0, q.size() > 0}, 1);
                if (q.size() > 0) begin
                    check_result("stream", {8'h0, sum0}, cout0, ovf0, zero0, q[0]);
                    if (out_ready) begin
                        $display("stream out %0d: sum=%h cout=%b ovf=%b zero=%b",
                                 delivered, sum0, cout0, ovf0, zero0);
                        void'(q.pop_front());
                        delivered++;
                    end
                end
            end
            fire = in_valid && in_ready0;
            if (fire) begin
                q.push_back(ref_op(8, {8'h0, a8}, {8'h0, b8}, cin, sub));
                accepted++;
            end
            @(negedge clk);
            if (fire) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            end
            cyc++;
        end
        in_valid = 1'b0;
        check_eq("stream finished in budget", {31'h0, cyc < 400}, 1);
        check_eq("stream delivered", delivered, 20);
    endtask

    task automatic run_reset();
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; cin = 1'b0; sub = 1'b0;
        a8 = 8'h7F; b8 = 8'h01; a16 = 16'h7FFF; b16 = 16'h0001;
        @(negedge clk);
        a8 = 8'hFF; a16 = 16'hFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_eq("pre-reset out_valid n8s2", {31'h0, out_valid0}, 1);
        rst_n = 1'b0;
        #1;
        check_eq("reset out_valid n8s2", {31'h0, out_valid0}, 0);
        check_result("reset n8s2", {8'h0, sum0}, cout0, ovf0, zero0, '0);
        check_eq("reset out_valid n16s4", {31'h0, out_valid1}, 0);
        check_eq("reset sum n16s4", {16'h0, sum1}, 0);
        check_eq("reset out_valid n8s1", {31'h0, out_valid2}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("no stale result after reset", {29'h0, out_valid0, out_valid1, out_valid2}, 0);
        end
        run_directed("post-reset", 8'h3C, 8'h0A, 16'h3C3C, 16'h0A0A, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        check_eq("reset out_valid n8s2", {31'h0, out_valid0}, 0);
        check_result("reset n8s2", {8'h0, sum0}, cout0, ovf0, zero0, '0);
        check_eq("reset in_ready n8s2", {31'h0, in_ready0}, 1);
        check_eq("reset out_valid n16s4", {31'h0, out_valid1}, 0);
        check_eq("reset out_valid n8s1", {31'h0, out_valid2}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle in_ready n16s4", {31'h0, in_ready1}, 1);

        run_directed("ff+01",   8'hFF, 8'h01, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_directed("7f+01",   8'h7F, 8'h01, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_directed("0f+00+1", 8'h0F, 8'h00, 16'h0FFF, 16'h0000, 1'b1, 1'b0);
        run_directed("05-07",   8'h05, 8'h07, 16'h0005, 16'h0007, 1'b0, 1'b1);
        run_directed("80-01",   8'h80, 8'h01, 16'h8000, 16'h0001, 1'b0, 1'b1);
        run_directed("10-0f-1", 8'h10, 8'h0F, 16'h0010, 16'h000F, 1'b1, 1'b1);

        run_stream();
        run_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
